// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer
//   Upstream driver for a JK flip-flop. Commands (hold/reset/set/toggle plus a
//   repeat length) arrive over a valid/ready handshake and queue in a small FIFO.
//   Each command is replayed onto registered J/K outputs for cmd_len+1 cycles,
//   back-to-back with no bubble while the FIFO holds more work. A reference model
//   of Q runs alongside and a sticky flag reports any divergence of fed-back Q.
//
// Ports
//   clk           clock, all state on rising edge
//   rst           asynchronous active-low reset
//   cmd_valid     command present on cmd_op / cmd_len
//   cmd_ready     FIFO not full (depends on fifo_count only)
//   cmd_op        {J,K}: 00 hold, 01 reset, 10 set, 11 toggle
//   cmd_len       repeat length minus one
//   q_in          Q fed back from the flip-flop
//   clr_mismatch  synchronous clear of mismatch (wins over a same-cycle set)
//   J, K          registered flip-flop inputs
//   busy          high while replaying a command
//   exp_q         model of the flip-flop Q
//   mismatch      sticky divergence flag
//   fifo_count    entries currently buffered, 0..DEPTH
module jk_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     q_in,
  input  logic                     clr_mismatch,
  output logic                     J,
  output logic                     K,
  output logic                     busy,
  output logic                     exp_q,
  output logic                     mismatch,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = LEN_W + 2;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t             state_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [LEN_W-1:0]   remaining_reg;
  logic               j_reg;
  logic               k_reg;
  logic               exp_q_reg;
  logic               mismatch_reg;

  // Command storage; entry layout is {op[1:0], len[LEN_W-1:0]}.
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [ENT_W-1:0]   head;
  logic [1:0]         head_op;
  logic [LEN_W-1:0]   head_len;

  logic               push;
  logic               pop;
  logic               fifo_nonempty;

  assign cmd_ready     = (count_reg < FULL_COUNT);
  assign push          = cmd_valid & cmd_ready;
  assign fifo_nonempty = (count_reg != '0);

  // The head is read combinationally so a pop at an edge loads J/K at that
  // same edge; this is what makes back-to-back commands gap-free.
  assign head     = mem[rd_ptr_reg];
  assign head_op  = head[ENT_W-1:LEN_W];
  assign head_len = head[LEN_W-1:0];

  // Pop when idle with work pending, or when the current command has spent
  // its last cycle. count_reg is the pre-edge value, so a push this edge is
  // never popped in the same edge.
  assign pop = fifo_nonempty &
               ((state_reg == IDLE) || (remaining_reg == '0));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {cmd_op, cmd_len};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      remaining_reg <= '0;
      j_reg         <= 1'b0;
      k_reg         <= 1'b0;
      exp_q_reg     <= 1'b0;
      mismatch_reg  <= 1'b0;
    end else begin
      // FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of 2.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase

      // Replay FSM
      case (state_reg)
        IDLE: begin
          if (pop) begin
            {j_reg, k_reg} <= head_op;
            remaining_reg  <= head_len;
            state_reg      <= DRIVE;
          end else begin
            j_reg <= 1'b0;
            k_reg <= 1'b0;
          end
        end
        DRIVE: begin
          if (remaining_reg != '0) begin
            remaining_reg <= remaining_reg - LEN_W'(1);
          end else if (pop) begin
            {j_reg, k_reg} <= head_op;
            remaining_reg  <= head_len;
          end else begin
            j_reg     <= 1'b0;
            k_reg     <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Model the downstream flip-flop, which samples the same J/K this edge.
      case ({j_reg, k_reg})
        2'b01:   exp_q_reg <= 1'b0;
        2'b10:   exp_q_reg <= 1'b1;
        2'b11:   exp_q_reg <= ~exp_q_reg;
        default: exp_q_reg <= exp_q_reg;
      endcase

      if (clr_mismatch) begin
        mismatch_reg <= 1'b0;
      end else if (q_in != exp_q_reg) begin
        mismatch_reg <= 1'b1;
      end
    end
  end

  assign J          = j_reg;
  assign K          = k_reg;
  assign busy       = (state_reg == DRIVE);
  assign exp_q      = exp_q_reg;
  assign mismatch   = mismatch_reg;
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// tb_jk_cmd_sequencer
//   Directed bench for jk_cmd_sequencer. A behavioural JK flip-flop sharing the
//   DUT reset closes the Q loop; q_in can be overridden to inject divergence.
module tb_jk_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_len;
  logic       q_in;
  logic       clr_mismatch;
  logic       J;
  logic       K;
  logic       busy;
  logic       exp_q;
  logic       mismatch;
  logic [2:0] fifo_count;

  logic       ff_q;
  logic       force_en;
  logic       force_val;

  int         checks = 0;
  int         errors = 0;
  bit         chk_en = 1'b0;
  logic [1:0] exp_jk_q[$];

  jk_cmd_sequencer #(.DEPTH(4), .LEN_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_len      (cmd_len),
    .q_in         (q_in),
    .clr_mismatch (clr_mismatch),
    .J            (J),
    .K            (K),
    .busy         (busy),
    .exp_q        (exp_q),
    .mismatch     (mismatch),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Real JK flip-flop downstream of the DUT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ff_q <= 1'b0;
    else begin
      case ({J, K})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  assign q_in = force_en ? force_val : ff_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one edge and settle; optionally compare J/K against the stream.
  task automatic step();
    @(posedge clk);
    #1;
    if (chk_en && exp_jk_q.size() != 0) begin
      chk("stream_jk", {30'd0, J, K}, {30'd0, exp_jk_q.pop_front()});
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] len);
    bit   done;
    logic rdy;
    done      = 1'b0;
    cmd_op    = op;
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      rdy = cmd_ready;
      step();
      if (rdy) done = 1'b1;
    end
    cmd_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
    $display("push op=%b len=%0d accepted=%0d count=%0d", op, len, done, fifo_count);
  endtask

  task automatic add(input logic [1:0] op, input int n);
    for (int i = 0; i < n; i++) exp_jk_q.push_back(op);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (!busy && fifo_count == 3'd0) ok = 1'b1;
      else step();
    end
    if (!ok) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_len = 4'd0;
    clr_mismatch = 1'b0; force_en = 1'b0; force_val = 1'b0;

    // Reset state
    step(); step();
    chk("rst_J", {31'd0, J}, 32'd0);
    chk("rst_K", {31'd0, K}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_expq", {31'd0, exp_q}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    rst = 1'b1;
    step();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);

    // 1: reset mid-DRIVE with one command still queued
    push(2'b11, 4'd7);             // E0
    push(2'b10, 4'd3);             // E1: pops toggle, queues set
    step();                        // E2: exp_q toggled to 1
    chk("t1_pre_busy", {31'd0, busy}, 32'd1);
    chk("t1_pre_expq", {31'd0, exp_q}, 32'd1);
    chk("t1_pre_count", {29'd0, fifo_count}, 32'd1);
    rst = 1'b0;
    #2;
    chk("t1_J", {31'd0, J}, 32'd0);
    chk("t1_K", {31'd0, K}, 32'd0);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    chk("t1_expq", {31'd0, exp_q}, 32'd0);
    chk("t1_count", {29'd0, fifo_count}, 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("t1_ready", {31'd0, cmd_ready}, 32'd1);
    step();
    chk("t1_post_busy", {31'd0, busy}, 32'd0);
    chk("t1_post_count", {29'd0, fifo_count}, 32'd0);

    // 2: set len=0 into empty FIFO, one-cycle drive starting the edge after push
    push(2'b10, 4'd0);             // edge N
    chk("t2_N_J", {31'd0, J}, 32'd0);
    chk("t2_N_count", {29'd0, fifo_count}, 32'd1);
    step();                        // N+1
    chk("t2_N1_JK", {30'd0, J, K}, 32'd2);
    chk("t2_N1_busy", {31'd0, busy}, 32'd1);
    chk("t2_N1_expq", {31'd0, exp_q}, 32'd0);
    step();                        // N+2
    chk("t2_N2_JK", {30'd0, J, K}, 32'd0);
    chk("t2_N2_busy", {31'd0, busy}, 32'd0);
    chk("t2_N2_expq", {31'd0, exp_q}, 32'd1);

    // Fresh reset so the toggle sequence starts from Q=0
    rst = 1'b0; step(); rst = 1'b1; step();

    // 3: toggle len=2 then reset len=0, back to back
    push(2'b11, 4'd2);             // N
    push(2'b01, 4'd0);             // N+1: toggle loaded
    chk("t3_1_JK", {30'd0, J, K}, 32'd3);
    chk("t3_1_expq", {31'd0, exp_q}, 32'd0);
    step();
    chk("t3_2_JK", {30'd0, J, K}, 32'd3);
    chk("t3_2_expq", {31'd0, exp_q}, 32'd1);
    step();
    chk("t3_3_JK", {30'd0, J, K}, 32'd3);
    chk("t3_3_expq", {31'd0, exp_q}, 32'd0);
    step();
    chk("t3_4_JK", {30'd0, J, K}, 32'd1);
    chk("t3_4_expq", {31'd0, exp_q}, 32'd1);
    step();
    chk("t3_5_JK", {30'd0, J, K}, 32'd0);
    chk("t3_5_expq", {31'd0, exp_q}, 32'd0);
    chk("t3_5_busy", {31'd0, busy}, 32'd0);

    // 4: overfill while a 16-cycle hold drains slowly
    push(2'b00, 4'd15);            // E0
    exp_jk_q.delete();
    add(2'b00, 16);                // hold command E1..E16
    add(2'b10, 2); add(2'b01, 1); add(2'b11, 3);
    add(2'b00, 2); add(2'b10, 1); add(2'b01, 4);
    add(2'b00, 2);                 // back to idle
    chk_en = 1'b1;
    push(2'b10, 4'd1);
    push(2'b01, 4'd0);
    push(2'b11, 4'd2);
    push(2'b00, 4'd1);
    chk("t4_full_count", {29'd0, fifo_count}, 32'd4);
    chk("t4_full_ready", {31'd0, cmd_ready}, 32'd0);
    push(2'b10, 4'd0);
    push(2'b01, 4'd3);
    for (int i = 0; i < 100 && exp_jk_q.size() != 0; i++) step();
    chk("t4_stream_done", exp_jk_q.size(), 32'd0);
    chk_en = 1'b0;
    chk("t4_end_busy", {31'd0, busy}, 32'd0);
    chk("t4_end_count", {29'd0, fifo_count}, 32'd0);
    chk("t4_mismatch", {31'd0, mismatch}, 32'd0);

    // 5: real flip-flop in the loop: hold/set/hold/reset/toggle/toggle
    push(2'b00, 4'd1);
    push(2'b10, 4'd0);
    push(2'b00, 4'd2);
    push(2'b01, 4'd1);
    push(2'b11, 4'd0);
    push(2'b11, 4'd2);
    wait_idle("t5_idle_timeout");
    step();
    chk("t5_expq", {31'd0, exp_q}, 32'd0);
    chk("t5_ffq", {31'd0, ff_q}, 32'd0);
    chk("t5_mismatch", {31'd0, mismatch}, 32'd0);

    // 6: forced divergence, stickiness, clear-wins-over-set
    force_val = 1'b1; force_en = 1'b1;
    step();
    force_en = 1'b0;
    chk("t6_set", {31'd0, mismatch}, 32'd1);
    step(); step();
    chk("t6_sticky", {31'd0, mismatch}, 32'd1);
    force_en = 1'b1; clr_mismatch = 1'b1;
    step();
    chk("t6_clr_wins", {31'd0, mismatch}, 32'd0);
    force_en = 1'b0; clr_mismatch = 1'b0;
    step();
    chk("t6_clear_holds", {31'd0, mismatch}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
